// File: rtl/aes_key_expand.sv
// aes_key_expand: AES key schedule using an external combinational S-box, round keys go out through a FIFO.
// Latency: w[i] is registered on the (i+1)th edge after start; round key r is readable after edge 4r+4.
// Backpressure: a full buffer with a pending push and no pop freezes word production until space opens.
// AES_KEY_EXPAND_LONGKEY_EN adds AES-192/256; when it is undefined only AES-128 is built.
module aes_key_expand #(
  parameter int OUT_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_i,
  output logic [31:0]  sub_o,
  input  logic [31:0]  sub_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);
`ifdef AES_KEY_EXPAND_LONGKEY_EN
  localparam int WIN = 8;
  localparam int KW  = 256;
`else
  localparam int WIN = 4;
  localparam int KW  = 128;
`endif
  localparam int IW = $clog2(WIN);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] key_q;
  logic [31:0]   win_q [WIN];
  logic [5:0]    widx_q;
  logic [2:0]    kcnt_q;
  logic [7:0]    rcon_q;
  logic [3:0]    nk_q;
  logic [5:0]    last_q;

  logic [3:0]    nk_sel;
  logic [5:0]    last_sel;
  logic          sub8_use;

`ifdef AES_KEY_EXPAND_LONGKEY_EN
  // Key length decode: 11 falls back to AES-128
  always_comb begin
    nk_sel   = 4'd4;
    last_sel = 6'd43;
    case (key_len)
      2'b01:   begin nk_sel = 4'd6; last_sel = 6'd51; end
      2'b10:   begin nk_sel = 4'd8; last_sel = 6'd59; end
      default: ;
    endcase
  end
  assign sub8_use = (state_q == EXPAND) && (nk_q == 4'd8) && (kcnt_q == 3'd4);
`else
  logic unused_cfg;
  assign nk_sel     = 4'd4;
  assign last_sel   = 6'd43;
  assign sub8_use   = 1'b0;
  assign unused_cfg = ^{key_len, key_i[127:0]};
`endif

  logic [IW-1:0] old_idx;
  logic [31:0]   w_prev, w_old, temp, w_new;
  logic          rot_use, active, push, full, pop, stall, adv, last_word, wr_en;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [131:0]  mem_q [2**PW];

  // Newest word sits at the top slot; w[i-Nk] is Nk slots below it (wraps mod WIN)
  assign old_idx   = IW'(0) - nk_q[IW-1:0];
  assign w_prev    = win_q[WIN-1];
  assign w_old     = win_q[old_idx];
  assign rot_use   = (state_q == EXPAND) && (kcnt_q == 3'd0);
  assign active    = (state_q != IDLE);
  assign push      = active && (widx_q[1:0] == 2'b11);
  assign full      = (cnt_q == CW'(OUT_DEPTH));
  assign rk_valid  = (cnt_q != '0);
  assign pop       = rk_valid && rk_ready;
  assign stall     = push && full && !pop;
  assign adv       = active && !stall;
  assign last_word = (widx_q == last_q);
  assign wr_en     = push && adv;
  assign busy      = active;
  assign done      = adv && last_word;

  // S-box request and the temp word that feeds the XOR with w[i-Nk]
  always_comb begin
    sub_o = 32'h0;
    temp  = w_prev;
    if (rot_use) begin
      sub_o = {w_prev[23:0], w_prev[31:24]};
      temp  = sub_i ^ {rcon_q, 24'h0};
    end else if (sub8_use) begin
      sub_o = w_prev;
      temp  = sub_i;
    end
    w_new = (state_q == LOAD) ? key_q[KW-1 -: 32] : (w_old ^ temp);
  end

  // Next-state: load Nk key words, then expand until the final word is pushed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (adv && (widx_q == 6'(nk_q - 4'd1))) state_d = EXPAND;
      EXPAND:  if (adv && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Word window, counters and rcon; all frozen while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      widx_q <= '0;
      kcnt_q <= '0;
      rcon_q <= 8'h01;
      nk_q   <= 4'd4;
      last_q <= 6'd43;
      for (int j = 0; j < WIN; j++) win_q[j] <= '0;
    end else if ((state_q == IDLE) && start) begin
      key_q  <= key_i[255 -: KW];
      widx_q <= '0;
      kcnt_q <= '0;
      rcon_q <= 8'h01;
      nk_q   <= nk_sel;
      last_q <= last_sel;
    end else if (adv) begin
      key_q  <= {key_q[KW-33:0], 32'h0};
      for (int j = 0; j < WIN-1; j++) win_q[j] <= win_q[j+1];
      win_q[WIN-1] <= w_new;
      widx_q <= widx_q + 6'd1;
      kcnt_q <= (kcnt_q == 3'(nk_q - 4'd1)) ? 3'd0 : kcnt_q + 3'd1;
      if (rot_use) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  // Buffer storage: round index plus the four most recent words
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {widx_q[5:2], win_q[WIN-3], win_q[WIN-2], win_q[WIN-1], w_new};
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= (wr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop)   rd_q <= (rd_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_q + PW'(1);
      if (wr_en && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!wr_en && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign rk_o     = rk_valid ? mem_q[rd_q][127:0]   : 128'h0;
  assign rk_idx_o = rk_valid ? mem_q[rd_q][131:128] : 4'h0;

endmodule
